// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: the byte-wide instruction memory port and the
// instruction hand-off to the datapath.
interface instruction_fetch_unit_if;
  // Memory:   MemReq/MemAddr are held stable until the one-cycle MemAck that
  //           completes the read. MemAck may arrive in the same cycle as MemReq.
  //           MemAck is ignored while MemReq=0.
  // Datapath: Instruction is held stable while InstrValid=1. A cycle with
  //           InstrValid=1 and InstrTaken=1 is the single transfer. BranchTaken
  //           and BranchTarget are sampled only in that cycle.
  logic        MemReq;
  logic [23:0] MemAddr;
  logic [7:0]  MemRdData;
  logic        MemAck;
  logic [23:0] Instruction;
  logic        InstrValid;
  logic        InstrTaken;
  logic        BranchTaken;
  logic [23:0] BranchTarget;

  modport master (
    output MemReq, MemAddr, Instruction, InstrValid,
    input  MemRdData, MemAck, InstrTaken, BranchTaken, BranchTarget
  );

  modport slave (
    input  MemReq, MemAddr, Instruction, InstrValid,
    output MemRdData, MemAck, InstrTaken, BranchTaken, BranchTarget
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Front end of the 24-bit CPU: owns the PC and assembles each instruction
// from three big-endian byte reads, then hands it to the datapath.
module instruction_fetch_unit #(
  parameter logic [23:0] RESET_VECTOR = 24'h000000,
  parameter logic [3:0]  HALT_OPCODE  = 4'hF,
  parameter bit          HALT_ENABLE  = 1'b1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  instruction_fetch_unit_if.master       bus,
  output logic [23:0]                    PC,
  output logic                           Halted,
  output logic [15:0]                    RetireCount,
  output logic [2:0]                     DebugState
);

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic [23:0] instr_q, instr_d;
  logic [15:0] retire_q, retire_d;

  logic        mem_req;
  logic [23:0] mem_addr;
  logic        instr_valid;
  logic        halted;
  logic        is_halt;

  assign is_halt = HALT_ENABLE && (instr_q[23:20] == HALT_OPCODE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= FETCH0;
      pc_q     <= RESET_VECTOR;
      instr_q  <= 24'h000000;
      retire_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retire_d    = retire_q;
    mem_req     = 1'b0;
    mem_addr    = pc_q;
    instr_valid = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      FETCH0: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (bus.MemAck) begin
          instr_d[23:16] = bus.MemRdData;
          state_d        = FETCH1;
        end
      end
      FETCH1: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + 24'd1;
        if (bus.MemAck) begin
          instr_d[15:8] = bus.MemRdData;
          state_d       = FETCH2;
        end
      end
      FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + 24'd2;
        if (bus.MemAck) begin
          instr_d[7:0] = bus.MemRdData;
          state_d      = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (bus.InstrTaken) begin
          retire_d = retire_q + 16'd1;
          // A halt keeps PC on the halt instruction so software can see where it stopped.
          if (is_halt) begin
            state_d = HALTED;
          end else begin
            pc_d    = bus.BranchTaken ? bus.BranchTarget : (pc_q + 24'd3);
            state_d = FETCH0;
          end
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH0;
      end
    endcase
  end

  // The request is masked during reset so an abandoned fetch never leaks onto the bus.
  assign bus.MemReq      = mem_req & ~Reset;
  assign bus.MemAddr     = mem_addr;
  assign bus.Instruction = instr_q;
  assign bus.InstrValid  = instr_valid;
  assign PC              = pc_q;
  assign Halted          = halted;
  assign RetireCount     = retire_q;
  assign DebugState      = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory responder with
// programmable wait states and a behavioural PC/retire model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [23:0] pc;
  logic        halted;
  logic [15:0] retire;
  logic [2:0]  dbg_state;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_VECTOR(24'h000000),
    .HALT_OPCODE (4'hF),
    .HALT_ENABLE (1'b1)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .bus        (bus),
    .PC         (pc),
    .Halted     (halted),
    .RetireCount(retire),
    .DebugState (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a few fixed bytes, everything else a hash whose top bit
  // is clear so random fetches never decode as the halt opcode.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    logic [7:0] h;
    case (a)
      24'h000000: rom_byte = 8'h12;
      24'h000001: rom_byte = 8'h34;
      24'h000002: rom_byte = 8'h56;
      24'h000100: rom_byte = 8'hF0;
      24'h000101: rom_byte = 8'h00;
      24'h000102: rom_byte = 8'h00;
      default: begin
        h        = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        rom_byte = {1'b0, h[6:0]};
      end
    endcase
  endfunction

  function automatic logic [23:0] word_at(input logic [23:0] a);
    logic [23:0] a1, a2;
    a1 = a + 24'd1;
    a2 = a + 24'd2;
    word_at = {rom_byte(a), rom_byte(a1), rom_byte(a2)};
  endfunction

  // Memory responder: acks after wait_cfg idle request cycles.
  int   wait_cfg;
  int   wcnt;
  logic stray_ack;

  assign bus.MemAck    = (bus.MemReq && (wcnt >= wait_cfg)) || stray_ack;
  assign bus.MemRdData = rom_byte(bus.MemAddr);

  always @(posedge clk) begin
    if (!bus.MemReq || bus.MemAck) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
  end

  // Reference model and scoreboard.
  logic [23:0] exp_pc;
  logic [23:0] exp_instr;
  logic [15:0] exp_retire;
  bit          exp_halted;
  logic [23:0] exp_q[$];

  int n_checks;
  int n_fail;

  // Observation of one fetch, starting at a falling edge in FETCH0.
  int          lat;
  int          n_ack;
  int          unstable;
  bit          timed_out;
  logic [23:0] acked[3];

  task automatic run_fetch();
    bit          prev_wait;
    logic [23:0] prev_addr;
    lat = 0; n_ack = 0; unstable = 0; timed_out = 0;
    prev_wait = 0; prev_addr = '0;
    exp_q.delete();
    while (1) begin
      #1;
      if (bus.InstrValid) break;
      if (prev_wait && (!bus.MemReq || bus.MemAddr !== prev_addr)) unstable++;
      if (bus.MemReq && bus.MemAck) begin
        if (n_ack < 3) acked[n_ack] = bus.MemAddr;
        n_ack++;
      end
      prev_wait = bus.MemReq && !bus.MemAck;
      prev_addr = bus.MemAddr;
      if (lat >= 100) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_pc + 24'(i));
  endtask

  // Accept the presented instruction; called just after a falling edge in VALID.
  task automatic take(input bit br, input logic [23:0] tgt, input int next_wait);
    bus.InstrTaken   = 1'b1;
    bus.BranchTaken  = br;
    bus.BranchTarget = tgt;
    wait_cfg         = next_wait;
    exp_retire++;
    if (exp_instr[23:20] == 4'hF) begin
      exp_halted = 1'b1;
    end else begin
      exp_pc    = br ? tgt : exp_pc + 24'd3;
      exp_instr = word_at(exp_pc);
    end
    @(negedge clk);
    bus.InstrTaken   = 1'b0;
    bus.BranchTaken  = 1'($urandom_range(0, 1));
    bus.BranchTarget = 24'($urandom);
  endtask

  task automatic check_fetch(input string name);
    n_checks++;
    if (timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no InstrValid within 100 cycles, required InstrValid", name);
    end
    n_checks++;
    if (bus.Instruction !== exp_instr) begin
      n_fail++;
      $display("FAIL %s_instr: got %h required %h", name, bus.Instruction, exp_instr);
    end
    n_checks++;
    if (pc !== exp_pc) begin
      n_fail++;
      $display("FAIL %s_pc: got %h required %h", name, pc, exp_pc);
    end
    n_checks++;
    if (retire !== exp_retire) begin
      n_fail++;
      $display("FAIL %s_retire: got %0d required %0d", name, retire, exp_retire);
    end
    n_checks++;
    if (n_ack !== 3) begin
      n_fail++;
      $display("FAIL %s_nack: got %0d required 3", name, n_ack);
    end
    for (int i = 0; i < 3; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (acked[i] !== e) begin
        n_fail++;
        $display("FAIL %s_addr%0d: got %h required %h", name, i, acked[i], e);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.InstrTaken = 1'b0;
    stray_ack = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    @(negedge clk);
    exp_pc = 24'h000000; exp_retire = 16'd0; exp_halted = 1'b0;
    exp_instr = word_at(exp_pc);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (pc !== 24'h000000) begin n_fail++; $display("FAIL reset_pc: got %h required 000000", pc); end
    n_checks++;
    if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL reset_memreq: got %b required 0", bus.MemReq); end
    n_checks++;
    if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.InstrValid); end
    n_checks++;
    if (bus.Instruction !== 24'h0) begin n_fail++; $display("FAIL reset_instr: got %h required 000000", bus.Instruction); end
    n_checks++;
    if (halted !== 1'b0 || retire !== 16'd0) begin
      n_fail++; $display("FAIL reset_status: got halted=%b retire=%0d required 0/0", halted, retire);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    run_fetch();
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL zero_wait_latency: got %0d required 3", lat); end
    n_checks++;
    if (exp_instr !== 24'h123456) begin n_fail++; $display("FAIL zero_wait_rom: got %h required 123456", exp_instr); end
    check_fetch("zero_wait");
  endtask

  task automatic test_no_branch();
    take(1'b0, 24'h0, 0);
    run_fetch();
    check_fetch("no_branch");
  endtask

  task automatic test_branch();
    take(1'b1, 24'h000030, 0);
    run_fetch();
    check_fetch("branch");
  endtask

  task automatic test_wait_states();
    take(1'b0, 24'h0, 2);
    run_fetch();
    check_fetch("wait");
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL wait_latency: got %0d required 9", lat); end
    n_checks++;
    if (unstable !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d unstable cycles required 0", unstable); end
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.InstrValid !== 1'b1 || bus.Instruction !== exp_instr || pc !== exp_pc || bus.MemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: got valid=%b instr=%h pc=%h req=%b required 1/%h/%h/0",
               bus.InstrValid, bus.Instruction, pc, bus.MemReq, exp_instr, exp_pc);
    end
    stray_ack = 1'b0;
  endtask

  task automatic test_wrap();
    take(1'b1, 24'hFFFFFE, 0);
    run_fetch();
    check_fetch("wrap_fetch");
    take(1'b0, 24'h0, 1);
    run_fetch();
    check_fetch("wrap_next");
    n_checks++;
    if (pc !== 24'h000001) begin n_fail++; $display("FAIL wrap_pc: got %h required 000001", pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit          br;
      logic [23:0] tgt;
      int          w;
      br  = 1'($urandom_range(0, 1));
      tgt = 24'($urandom);
      w   = $urandom_range(0, 3);
      take(br, tgt, w);
      if (exp_halted) break;
      run_fetch();
      check_fetch("random");
      n_checks++;
      if (lat !== 3 * (w + 1)) begin
        n_fail++; $display("FAIL random_latency: got %0d required %0d", lat, 3 * (w + 1));
      end
    end
  endtask

  task automatic test_halt();
    take(1'b1, 24'h000100, 0);
    run_fetch();
    check_fetch("halt_fetch");
    take(1'b1, 24'h000200, 0);
    #1;
    n_checks++;
    if (halted !== 1'b1 || bus.InstrValid !== 1'b0 || bus.MemReq !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter: got halted=%b valid=%b req=%b required 1/0/0", halted, bus.InstrValid, bus.MemReq);
    end
    n_checks++;
    if (pc !== 24'h000100 || retire !== exp_retire) begin
      n_fail++; $display("FAIL halt_state: got pc=%h retire=%0d required 000100/%0d", pc, retire, exp_retire);
    end
    bus.InstrTaken = 1'b1;
    stray_ack = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (halted !== 1'b1 || bus.MemReq !== 1'b0 || pc !== 24'h000100 || retire !== exp_retire) begin
      n_fail++; $display("FAIL halt_hold: got halted=%b req=%b pc=%h retire=%0d", halted, bus.MemReq, pc, retire);
    end
    apply_reset();
    #1;
    n_checks++;
    if (halted !== 1'b0 || retire !== 16'd0) begin
      n_fail++; $display("FAIL halt_recover: got halted=%b retire=%0d required 0/0", halted, retire);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stray_ack = 1'b1;
    #1;
    n_checks++;
    if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req: got %b required 0", bus.MemReq); end
    @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== 3'd0 || pc !== 24'h000000 || bus.InstrValid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: got state=%0d pc=%h valid=%b required 0/000000/0", dbg_state, pc, bus.InstrValid);
    end
    stray_ack = 1'b0;
    rst = 1'b0;
    run_fetch();
    check_fetch("mid_reset");
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL mid_reset_latency: got %0d required 3", lat); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    stray_ack = 1'b0;
    wait_cfg = 0;
    bus.InstrTaken = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = 24'h0;
    test_reset();
    test_zero_wait();
    test_no_branch();
    test_branch();
    test_wait_states();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the 24-bit single-cycle CPU. Sits directly upstream of the datapath.
- Owns the PC. Fetches each 24-bit instruction as three byte reads from a byte-wide instruction memory over a req/ack handshake. Presents the instruction to the datapath with a valid/taken handshake.
- Applies the datapath's branch decision to form the next PC: PC+3, or the branch target.

Parameters:
- RESET_VECTOR, 24'h000000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode (Instruction[23:20]) that halts fetch when taken.
- HALT_ENABLE, 1, 1 = halt detection active; 0 = HALT_OPCODE treated as an ordinary instruction.

Ports:
- Clock, input, 1, single clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high.
- MemReq, output, 1, byte read request to instruction memory.
- MemAddr, output, 24, byte address of the current request.
- MemRdData, input, 8, read byte; valid when MemAck=1.
- MemAck, input, 1, one-cycle completion of the current request.
- Instruction, output, 24, assembled instruction to the datapath.
- InstrValid, output, 1, Instruction is valid.
- InstrTaken, input, 1, datapath consumes Instruction this cycle.
- BranchTaken, input, 1, branch decision for the instruction being taken.
- BranchTarget, input, 24, next PC if BranchTaken=1.
- PC, output, 24, address of the instruction being fetched or presented.
- Halted, output, 1, fetch stopped on the halt opcode.
- RetireCount, output, 16, number of instructions taken; wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high; it wins over every other input on the same edge.
- Reset values:
  - PC=RESET_VECTOR, state=FETCH0, Instruction=0.
  - InstrValid=0, Halted=0, RetireCount=0.
  - MemReq is gated by !Reset, so it is 0 while Reset=1.
- Reset mid-operation: any outstanding request is abandoned. An ack arriving in the reset cycle is ignored.
- States: FETCH0, FETCH1, FETCH2, VALID, HALTED.
- FETCHn (n=0..2):
  - MemReq=1 and MemAddr=PC+n, mod 2^24.
  - MemReq and MemAddr are held stable until MemAck.
  - On MemAck, MemRdData is latched and the FSM advances to the next state. FETCH2 advances to VALID.
  - Byte order is big-endian: PC→Instruction[23:16], PC+1→[15:8], PC+2→[7:0].
- Zero-wait memory: MemAck may assert in the same cycle MemReq rises.
  - Minimum latency is 3 cycles from entering FETCH0 to InstrValid=1.
  - Each wait cycle adds 1.
- MemAck while MemReq=0 (VALID, HALTED, Reset) is ignored.
- VALID:
  - InstrValid=1, MemReq=0. Instruction and PC are held stable until InstrTaken.
  - On InstrTaken, RetireCount increments and InstrValid drops next cycle.
  - Next PC = BranchTaken ? BranchTarget : PC+3, with 24-bit wrap (24'hFFFFFE+3 = 24'h000001).
  - If HALT_ENABLE=1 and Instruction[23:20]==HALT_OPCODE, the FSM goes to HALTED and PC holds the halt instruction's address. Otherwise it goes to FETCH0.
- Inputs ignored outside VALID: InstrTaken, BranchTaken and BranchTarget are ignored unless state=VALID and InstrTaken=1.
- Misaligned BranchTarget (not a multiple of 3) is fetched as given; no alignment check.
- HALTED: Halted=1, InstrValid=0, MemReq=0. The FSM stays here until Reset.
- Back-to-back fetch: InstrTaken in VALID gives FETCH0 on the next cycle. There is no prefetch, so one instruction is in flight at a time.
- RetireCount increments exactly once per accepted InstrTaken, including the halt instruction.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req) with ROM bytes 12,34,56 at 0..2. Expect: MemAddr 0,1,2 on consecutive cycles; InstrValid=1 on cycle 3 with Instruction=24'h123456 and PC=0.
- Taken instruction with no branch: InstrTaken=1, BranchTaken=0. Expect: next fetch at PC=3 with MemAddr=3; RetireCount=1.
- Branch: InstrTaken=1, BranchTaken=1, BranchTarget=24'h000030. Expect: MemAddr 30,31,32 and PC=24'h000030.
- Wait states: ack delayed 2 cycles per byte. Expect: MemReq and MemAddr stable while waiting; InstrValid after 9 cycles. A stray MemAck held during VALID has no effect.
- Halt: fetch 24'hF00000 then InstrTaken. Expect: Halted=1, MemReq stays 0, InstrValid=0; RetireCount incremented; PC unchanged; recovers only after Reset.
- Edge cases:
  - PC=24'hFFFFFE, taken, no branch: next PC=24'h000001.
  - Reset asserted during FETCH1 with MemAck=1: state returns to FETCH0, PC=RESET_VECTOR, no partial instruction issued.
